// File: rtl/yarp_pkg.sv
// Shared YARP types: ALU ops, register-file write mux, instruction types,
// memory access sizes, multi-cycle controller states and EXEC control bundle.
package yarp_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_SLL  = 4'b0010,
      OP_SLT  = 4'b0100,
      OP_SLTU = 4'b0110,
      OP_XOR  = 4'b1000,
      OP_SRL  = 4'b1010,
      OP_SRA  = 4'b1011,
      OP_OR   = 4'b1100,
      OP_AND  = 4'b1110
   } alu_op_t;

   typedef enum logic [1:0] {
      ALU_RES     = 2'b00,
      DATA_MEM    = 2'b01,
      IMMIDIET    = 2'b10,
      NXT_PC_ADDR = 2'b11
   } rf_mux_t;

   typedef enum logic [2:0] {
      R_TYPE,
      I_TYPE,
      S_TYPE,
      B_TYPE,
      U_TYPE,
      J_TYPE
   } instr_type_t;

   typedef enum logic [1:0] {
      BYTE      = 2'b00,
      HALF_WORD = 2'b01,
      WORD      = 2'b11
   } mem_size_t;

   typedef enum logic [2:0] {
      RESET,
      FETCH,
      FETCH_WAIT,
      DECODE,
      EXEC,
      MEM,
      MEM_WAIT,
      TRAP
   } mc_state_t;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   typedef struct packed {
      logic       pc_sel;
      logic       op1sel;
      logic       op2sel;
      logic [3:0] alu_func;
      logic [1:0] rf_wr_data;
      logic       rf_wr_en;
      logic       is_mem;
      logic [1:0] data_byte;
      logic       data_wr;
      logic       zero_extnd;
   } exec_ctrl_t;

   function automatic logic [1:0] mem_size(input logic [1:0] funct3_lo);
      case (funct3_lo)
         2'b00:   mem_size = BYTE;
         2'b01:   mem_size = HALF_WORD;
         default: mem_size = WORD;
      endcase
   endfunction

   // States in which the controller is blocked on an external handshake.
   function automatic logic is_wait_state(input mc_state_t s);
      is_wait_state = (s == FETCH) || (s == FETCH_WAIT) || (s == MEM) || (s == MEM_WAIT);
   endfunction

endpackage

// File: rtl/yarp_mc_decode.sv
// Combinational per-type datapath control decode used by the multi-cycle
// controller during EXEC and the memory phases.
module yarp_mc_decode
   import yarp_pkg::*;
(
   input  instr_type_t instr_type_i,
   input  logic [6:0]  instr_opcode_i,
   input  logic [2:0]  instr_funct3_i,
   input  logic        instr_funct7_bit5_i,
   input  logic        branch_taken_i,
   output exec_ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (instr_type_i)
         R_TYPE: begin
            ctrl_o.alu_func = {instr_funct3_i, instr_funct7_bit5_i};
            ctrl_o.rf_wr_en = 1'b1;
         end
         I_TYPE: begin
            ctrl_o.op2sel = 1'b1;
            if (instr_opcode_i == OPC_LOAD) begin
               ctrl_o.alu_func   = OP_ADD;
               ctrl_o.is_mem     = 1'b1;
               ctrl_o.data_byte  = mem_size(instr_funct3_i[1:0]);
               ctrl_o.zero_extnd = instr_funct3_i[2];
            end else if (instr_opcode_i == OPC_JALR) begin
               ctrl_o.alu_func   = OP_ADD;
               ctrl_o.pc_sel     = 1'b1;
               ctrl_o.rf_wr_en   = 1'b1;
               ctrl_o.rf_wr_data = NXT_PC_ADDR;
            end else begin
               ctrl_o.alu_func = {instr_funct3_i, 1'b0};
               ctrl_o.rf_wr_en = 1'b1;
            end
         end
         S_TYPE: begin
            ctrl_o.op2sel    = 1'b1;
            ctrl_o.alu_func  = OP_ADD;
            ctrl_o.is_mem    = 1'b1;
            ctrl_o.data_wr   = 1'b1;
            ctrl_o.data_byte = mem_size(instr_funct3_i[1:0]);
         end
         B_TYPE: begin
            ctrl_o.op1sel   = 1'b1;
            ctrl_o.op2sel   = 1'b1;
            ctrl_o.alu_func = OP_ADD;
            ctrl_o.pc_sel   = branch_taken_i;
         end
         U_TYPE: begin
            ctrl_o.rf_wr_en = 1'b1;
            if (instr_opcode_i == OPC_AUIPC) begin
               ctrl_o.op1sel   = 1'b1;
               ctrl_o.op2sel   = 1'b1;
               ctrl_o.alu_func = OP_ADD;
            end else begin
               ctrl_o.rf_wr_data = IMMIDIET;
            end
         end
         J_TYPE: begin
            ctrl_o.op1sel     = 1'b1;
            ctrl_o.op2sel     = 1'b1;
            ctrl_o.alu_func   = OP_ADD;
            ctrl_o.pc_sel     = 1'b1;
            ctrl_o.rf_wr_en   = 1'b1;
            ctrl_o.rf_wr_data = NXT_PC_ADDR;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/yarp_mc_control.sv
// YARP multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM FSM with bus
// handshakes, wait-state timeout and sticky trap. YARP_MC_PERF_CNT_EN adds perf counters.
module yarp_mc_control
   import yarp_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        is_r_type_i,
   input  logic        is_i_type_i,
   input  logic        is_s_type_i,
   input  logic        is_b_type_i,
   input  logic        is_u_type_i,
   input  logic        is_j_type_i,
   input  logic [6:0]  instr_opcode_i,
   input  logic [2:0]  instr_funct3_i,
   input  logic        instr_funct7_bit5_i,
   input  logic        branch_taken_i,
   output logic        imem_req_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   output logic        ir_we_o,
   output logic        pc_we_o,
   output logic        pc_sel_o,
   output logic        op1sel_o,
   output logic        op2sel_o,
   output logic [3:0]  alu_func_o,
   output logic [1:0]  rf_wr_data_o,
   output logic        rf_wr_en_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   output logic [1:0]  data_byte_o,
   output logic        data_wr_o,
   output logic        zero_extnd_o,
   output logic        trap_o,
   output logic        busy_o
`ifdef YARP_MC_PERF_CNT_EN
   ,
   output logic [63:0] cycle_cnt_o,
   output logic [63:0] instret_cnt_o
`endif
);

   mc_state_t   state_q, state_d;
   logic [TO_W-1:0] to_cnt_q;
   logic        to_hit;
   logic        type_ok;
   instr_type_t instr_type;
   exec_ctrl_t  dec;

   assign type_ok = $onehot({is_r_type_i, is_i_type_i, is_s_type_i,
                             is_b_type_i, is_u_type_i, is_j_type_i});

   always_comb begin
      instr_type = R_TYPE;
      if (is_i_type_i)      instr_type = I_TYPE;
      else if (is_s_type_i) instr_type = S_TYPE;
      else if (is_b_type_i) instr_type = B_TYPE;
      else if (is_u_type_i) instr_type = U_TYPE;
      else if (is_j_type_i) instr_type = J_TYPE;
   end

   yarp_mc_decode u_decode (
      .instr_type_i        (instr_type),
      .instr_opcode_i      (instr_opcode_i),
      .instr_funct3_i      (instr_funct3_i),
      .instr_funct7_bit5_i (instr_funct7_bit5_i),
      .branch_taken_i      (branch_taken_i),
      .ctrl_o              (dec)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= RESET;
      else          state_q <= state_d;
   end

   // Counter restarts on every entry into a wait state and saturates at the limit.
   always_ff @(posedge clk) begin
      if (!reset_n)
         to_cnt_q <= '0;
      else if (is_wait_state(state_d) && (state_d != state_q))
         to_cnt_q <= '0;
      else if (is_wait_state(state_q) && (to_cnt_q != TO_W'(TIMEOUT_CYCLES)))
         to_cnt_q <= to_cnt_q + TO_W'(1);
   end

   assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
   assign busy_o = (state_q != RESET) && (state_q != TRAP);

   always_comb begin
      state_d      = state_q;
      imem_req_o   = 1'b0;
      ir_we_o      = 1'b0;
      pc_we_o      = 1'b0;
      pc_sel_o     = 1'b0;
      op1sel_o     = 1'b0;
      op2sel_o     = 1'b0;
      alu_func_o   = '0;
      rf_wr_data_o = '0;
      rf_wr_en_o   = 1'b0;
      data_req_o   = 1'b0;
      data_byte_o  = '0;
      data_wr_o    = 1'b0;
      zero_extnd_o = 1'b0;
      trap_o       = 1'b0;
      case (state_q)
         RESET: state_d = FETCH;
         FETCH: begin
            imem_req_o = 1'b1;
            if (imem_gnt_i) begin
               if (imem_rvalid_i) begin
                  ir_we_o = 1'b1;
                  state_d = DECODE;
               end else begin
                  state_d = FETCH_WAIT;
               end
            end else if (to_hit) begin
               state_d = TRAP;
            end
         end
         FETCH_WAIT: begin
            if (imem_rvalid_i) begin
               ir_we_o = 1'b1;
               state_d = DECODE;
            end else if (to_hit) begin
               state_d = TRAP;
            end
         end
         DECODE: state_d = type_ok ? EXEC : TRAP;
         EXEC: begin
            pc_sel_o     = dec.pc_sel;
            op1sel_o     = dec.op1sel;
            op2sel_o     = dec.op2sel;
            alu_func_o   = dec.alu_func;
            rf_wr_data_o = dec.rf_wr_data;
            if (dec.is_mem) begin
               state_d = MEM;
            end else begin
               rf_wr_en_o = dec.rf_wr_en;
               pc_we_o    = 1'b1;
               state_d    = FETCH;
            end
         end
         MEM: begin
            op1sel_o     = dec.op1sel;
            op2sel_o     = dec.op2sel;
            alu_func_o   = dec.alu_func;
            data_req_o   = 1'b1;
            data_byte_o  = dec.data_byte;
            data_wr_o    = dec.data_wr;
            zero_extnd_o = dec.zero_extnd;
            if (data_gnt_i) begin
               if (dec.data_wr) begin
                  pc_we_o = 1'b1;
                  state_d = FETCH;
               end else if (data_rvalid_i) begin
                  rf_wr_en_o   = 1'b1;
                  rf_wr_data_o = DATA_MEM;
                  pc_we_o      = 1'b1;
                  state_d      = FETCH;
               end else begin
                  state_d = MEM_WAIT;
               end
            end else if (to_hit) begin
               state_d = TRAP;
            end
         end
         MEM_WAIT: begin
            op1sel_o     = dec.op1sel;
            op2sel_o     = dec.op2sel;
            alu_func_o   = dec.alu_func;
            data_byte_o  = dec.data_byte;
            zero_extnd_o = dec.zero_extnd;
            if (data_rvalid_i) begin
               rf_wr_en_o   = 1'b1;
               rf_wr_data_o = DATA_MEM;
               pc_we_o      = 1'b1;
               state_d      = FETCH;
            end else if (to_hit) begin
               state_d = TRAP;
            end
         end
         TRAP: trap_o = 1'b1;
         default: state_d = RESET;
      endcase
   end

`ifdef YARP_MC_PERF_CNT_EN
   logic [63:0] cycle_cnt_q;
   logic [63:0] instret_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else if (state_q != TRAP) begin
         cycle_cnt_q <= cycle_cnt_q + 64'd1;
         if (pc_we_o) instret_cnt_q <= instret_cnt_q + 64'd1;
      end
   end

   assign cycle_cnt_o   = cycle_cnt_q;
   assign instret_cnt_o = instret_cnt_q;
`endif

endmodule
